// File: rtl/skin_frame_ctrl.sv
// Frame sequencer for the RGB->YUV skin-detect datapath: feeds pixels,
// realigns x/y tags with the returned skin flag, reports per-frame stats.
module skin_frame_ctrl #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int PIPE_LAT = 8,
    parameter int MIN_SKIN = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sof,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_red,
    input  logic [7:0]  s_grn,
    input  logic [7:0]  s_blu,
    output logic        dp_rst,
    output logic [17:0] dp_red,
    output logic [17:0] dp_grn,
    output logic [17:0] dp_blu,
    input  logic        dp_skind,
    output logic        busy,
    output logic [19:0] skin_count,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [8:0]  y_min,
    output logic [8:0]  y_max,
    output logic        face_found,
    output logic        result_valid
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q;
    logic [DW-1:0]  drain_q;
    logic [9:0]     x_q;
    logic [8:0]     y_q;
    logic           dp_rst_q;
    logic [17:0]    dp_red_q, dp_grn_q, dp_blu_q;

    // Tag = {valid, x, y}; entry 0 travels with the operands, the last
    // entry lines up with dp_skind PIPE_LAT cycles later.
    logic [19:0]    tag_q [0:PIPE_LAT];

    logic [19:0]    cnt_q, cnt_d;
    logic [9:0]     xmin_q, xmin_d, xmax_q, xmax_d;
    logic [8:0]     ymin_q, ymin_d, ymax_q, ymax_d;

    logic [19:0]    skin_count_q;
    logic [9:0]     x_min_q, x_max_q;
    logic [8:0]     y_min_q, y_max_q;
    logic           face_found_q;
    logic           result_valid_q;

    logic           hit;
    logic [9:0]     tx;
    logic [8:0]     ty;
    logic           last_px;

    assign tx      = tag_q[PIPE_LAT][18:9];
    assign ty      = tag_q[PIPE_LAT][8:0];
    assign hit     = tag_q[PIPE_LAT][19] & dp_skind;
    assign last_px = (x_q == 10'(H_RES - 1)) && (y_q == 9'(V_RES - 1));

    always_comb begin
        cnt_d  = cnt_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        if (hit) begin
            if (cnt_q != '1)
                cnt_d = cnt_q + 20'd1;
            if (cnt_q == '0) begin
                xmin_d = tx;
                xmax_d = tx;
                ymin_d = ty;
                ymax_d = ty;
            end else begin
                if (tx < xmin_q) xmin_d = tx;
                if (tx > xmax_q) xmax_d = tx;
                if (ty < ymin_q) ymin_d = ty;
                if (ty > ymax_q) ymax_d = ty;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            drain_q        <= '0;
            x_q            <= '0;
            y_q            <= '0;
            dp_rst_q       <= 1'b1;
            dp_red_q       <= '0;
            dp_grn_q       <= '0;
            dp_blu_q       <= '0;
            for (int i = 0; i <= PIPE_LAT; i++)
                tag_q[i] <= '0;
            cnt_q          <= '0;
            xmin_q         <= '0;
            xmax_q         <= '0;
            ymin_q         <= '0;
            ymax_q         <= '0;
            skin_count_q   <= '0;
            x_min_q        <= '0;
            x_max_q        <= '0;
            y_min_q        <= '0;
            y_max_q        <= '0;
            face_found_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            dp_red_q       <= '0;
            dp_grn_q       <= '0;
            dp_blu_q       <= '0;
            for (int i = PIPE_LAT; i > 0; i--)
                tag_q[i] <= tag_q[i-1];
            tag_q[0]       <= '0;
            cnt_q          <= cnt_d;
            xmin_q         <= xmin_d;
            xmax_q         <= xmax_d;
            ymin_q         <= ymin_d;
            ymax_q         <= ymax_d;

            // Start-of-frame overrides everything, including a final accept.
            if (sof) begin
                state_q  <= RUN;
                dp_rst_q <= 1'b0;
                x_q      <= '0;
                y_q      <= '0;
                for (int i = 0; i <= PIPE_LAT; i++)
                    tag_q[i] <= '0;
                cnt_q    <= '0;
                xmin_q   <= '0;
                xmax_q   <= '0;
                ymin_q   <= '0;
                ymax_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        dp_rst_q <= 1'b1;
                    end
                    RUN: begin
                        if (s_valid) begin
                            dp_red_q <= {10'b0, s_red};
                            dp_grn_q <= {10'b0, s_grn};
                            dp_blu_q <= {10'b0, s_blu};
                            tag_q[0] <= {1'b1, x_q, y_q};
                            if (last_px) begin
                                state_q <= DRAIN;
                                drain_q <= '0;
                                x_q     <= '0;
                                y_q     <= '0;
                            end else if (x_q == 10'(H_RES - 1)) begin
                                x_q <= '0;
                                y_q <= y_q + 9'd1;
                            end else begin
                                x_q <= x_q + 10'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_q == DW'(PIPE_LAT - 1))
                            state_q <= DONE;
                        else
                            drain_q <= drain_q + 1'b1;
                    end
                    DONE: begin
                        skin_count_q   <= cnt_d;
                        x_min_q        <= xmin_d;
                        x_max_q        <= xmax_d;
                        y_min_q        <= ymin_d;
                        y_max_q        <= ymax_d;
                        face_found_q   <= (cnt_d >= 20'(MIN_SKIN));
                        result_valid_q <= 1'b1;
                        state_q        <= IDLE;
                        dp_rst_q       <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign s_ready      = (state_q == RUN);
    assign busy         = (state_q != IDLE);
    assign dp_rst       = dp_rst_q;
    assign dp_red       = dp_red_q;
    assign dp_grn       = dp_grn_q;
    assign dp_blu       = dp_blu_q;
    assign skin_count   = skin_count_q;
    assign x_min        = x_min_q;
    assign x_max        = x_max_q;
    assign y_min        = y_min_q;
    assign y_max        = y_max_q;
    assign face_found   = face_found_q;
    assign result_valid = result_valid_q;

endmodule
